// File: rtl/std_bypass_arbiter_pkg.sv
// Shared types for the bypass arbiter: request/response structs of the bypass
// channel and the arbiter FSM state encoding.
package std_bypass_arbiter_pkg;

  localparam int unsigned BYPASS_ID_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } bypass_arb_state_e;

  typedef struct packed {
    logic                   req;
    logic [1:0]             reqtype;
    logic [3:0]             amo;
    logic [BYPASS_ID_W-1:0] id;
    logic [63:0]            addr;
    logic [63:0]            wdata;
    logic                   we;
    logic [7:0]             be;
    logic [1:0]             size;
  } bypass_req_t;

  typedef struct packed {
    logic        gnt;
    logic        valid;
    logic [63:0] rdata;
  } bypass_rsp_t;

endpackage

// File: rtl/std_bypass_arbiter_if.sv
// Bundles the client-side and miss-handler-side bypass signals of the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface std_bypass_arbiter_if
  import std_bypass_arbiter_pkg::*;
#(
  parameter int unsigned NR_PORTS = 4
);
  bypass_req_t req_i [NR_PORTS];
  bypass_rsp_t rsp_o [NR_PORTS];
  bypass_req_t bypass_req_o;
  bypass_rsp_t bypass_rsp_i;

  modport slave  (input  req_i, bypass_rsp_i, output rsp_o, bypass_req_o);
  modport master (output req_i, bypass_rsp_i, input  rsp_o, bypass_req_o);
endinterface

// File: rtl/std_bypass_arbiter_rr_picker.sv
// Combinational round-robin search: first set request bit at or after i_ptr,
// wrapping modulo NR_PORTS. One-hot has bit i set when port i wins.
module bypass_rr_picker #(
  parameter int unsigned NR_PORTS = 4
) (
  input  logic [NR_PORTS-1:0]         i_req,
  input  logic [$clog2(NR_PORTS)-1:0] i_ptr,
  output logic [NR_PORTS-1:0]         o_onehot,
  output logic [$clog2(NR_PORTS)-1:0] o_idx,
  output logic                        o_any
);
  localparam int unsigned IDX_W = $clog2(NR_PORTS);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_cand   = '0;
    for (int k = 0; k < NR_PORTS; k++) begin
      w_cand = IDX_W'((int'(i_ptr) + k) % NR_PORTS);
      if (!o_any && i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
    if (o_any) o_onehot[o_idx] = 1'b1;
  end
endmodule

// File: rtl/std_bypass_arbiter.sv
// Round-robin arbiter of uncached client requests onto the single bypass
// channel of the miss handler, one transaction in flight.
module std_bypass_arbiter
  import std_bypass_arbiter_pkg::*;
#(
  parameter int unsigned NR_PORTS = 4
) (
  input logic                 clk_i,
  input logic                 rst_i,
  std_bypass_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NR_PORTS);

  bypass_arb_state_e r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0]  r_sel;
  bypass_req_t       r_req;

  logic [NR_PORTS-1:0] w_req_vec;
  logic [NR_PORTS-1:0] w_pick_onehot;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_any;
  logic                w_load;
  bypass_req_t         w_win_req;
  logic [IDX_W-1:0]    w_sel_next;

  always_comb begin
    w_req_vec = '0;
    w_win_req = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      w_req_vec[i] = bus.req_i[i].req;
      if (w_pick_onehot[i]) w_win_req = bus.req_i[i];
    end
  end

  bypass_rr_picker #(.NR_PORTS(NR_PORTS)) u_picker (
    .i_req    (w_req_vec),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  assign w_sel_next = (r_sel == IDX_W'(NR_PORTS - 1)) ? '0 : r_sel + 1'b1;

  always_comb begin
    w_state_nxt      = r_state;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_load           = 1'b0;
    bus.bypass_req_o = '0;
    for (int i = 0; i < NR_PORTS; i++) bus.rsp_o[i] = '0;

    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_load      = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        bus.bypass_req_o     = r_req;
        bus.bypass_req_o.req = 1'b1;
        bus.bypass_req_o.id  = BYPASS_ID_W'(r_sel);
        if (bus.bypass_rsp_i.gnt) begin
          bus.rsp_o[r_sel].gnt = 1'b1;
          w_rr_ptr_nxt         = w_sel_next;
          // grant and response may coincide; forward both in that cycle
          if (bus.bypass_rsp_i.valid) begin
            bus.rsp_o[r_sel].valid = 1'b1;
            bus.rsp_o[r_sel].rdata = bus.bypass_rsp_i.rdata;
            w_state_nxt            = IDLE;
          end else begin
            w_state_nxt = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (bus.bypass_rsp_i.valid) begin
          bus.rsp_o[r_sel].valid = 1'b1;
          bus.rsp_o[r_sel].rdata = bus.bypass_rsp_i.rdata;
          w_state_nxt            = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_sel    <= '0;
      r_req    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      if (w_load) begin
        r_sel <= w_pick_idx;
        r_req <= w_win_req;
      end
    end
  end

  a_valid_needs_gnt: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_state == ISSUE && bus.bypass_rsp_i.valid) |-> bus.bypass_rsp_i.gnt);

  a_client_holds_req: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_state == ISSUE) |-> bus.req_i[r_sel].req);
endmodule

// File: tb/tb_std_bypass_arbiter.sv
// Directed bench for std_bypass_arbiter: single read, idle noise, fast
// response, contention, backpressured write and reset mid-transaction.
module tb_std_bypass_arbiter;
  import std_bypass_arbiter_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  std_bypass_arbiter_if #(.NR_PORTS(4)) bif ();

  std_bypass_arbiter #(.NR_PORTS(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bif.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  function automatic bypass_req_t mk_req(input logic [63:0] addr, input logic we,
                                         input logic [7:0] be, input logic [63:0] wdata,
                                         input logic [1:0] size, input logic [1:0] rtype,
                                         input logic [3:0] amo);
    bypass_req_t r;
    r         = '0;
    r.req     = 1'b1;
    r.addr    = addr;
    r.we      = we;
    r.be      = be;
    r.wdata   = wdata;
    r.size    = size;
    r.reqtype = rtype;
    r.amo     = amo;
    return r;
  endfunction

  function automatic bypass_req_t exp_issue(input bypass_req_t r, input int port);
    bypass_req_t e;
    e     = r;
    e.req = 1'b1;
    e.id  = 4'(port);
    return e;
  endfunction

  task automatic chk_quiet(input string tag, input int port);
    for (int i = 0; i < 4; i++)
      if (i != port) chk(tag, 256'(bif.rsp_o[i]), 256'(0));
  endtask

  bypass_req_t rd1, fr0, wr3, rq2, ra0, rb1;
  bypass_req_t cont [4];
  int order   [6] = '{0, 2, 3, 0, 2, 3};
  int ptr_exp [6] = '{1, 3, 0, 1, 3, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    bif.bypass_rsp_i = '0;
    for (int i = 0; i < 4; i++) bif.req_i[i] = '0;
    rd1 = mk_req(64'h8000_0010, 1'b0, 8'hFF, 64'h0, 2'd3, 2'd0, 4'h0);
    fr0 = mk_req(64'h8000_0040, 1'b1, 8'hF0, 64'hAAAA_5555_0000_FFFF, 2'd2, 2'd1, 4'h5);
    wr3 = mk_req(64'h8000_0100, 1'b1, 8'h0F, 64'h1111_2222_3333_4444, 2'd3, 2'd0, 4'h0);
    rq2 = mk_req(64'h8000_0200, 1'b0, 8'hFF, 64'h0, 2'd3, 2'd0, 4'h0);
    ra0 = mk_req(64'h8000_0300, 1'b0, 8'hFF, 64'h0, 2'd3, 2'd0, 4'h0);
    rb1 = mk_req(64'h8000_0400, 1'b0, 8'hFF, 64'h0, 2'd3, 2'd0, 4'h0);
    for (int i = 0; i < 4; i++)
      cont[i] = mk_req(64'h8000_1000 + 64'(i) * 64'h100, 1'b0, 8'hFF, 64'h0, 2'd3, 2'd0, 4'h0);

    // reset values
    step(); #1;
    chk("rst_state", 256'(dut.r_state), 256'(IDLE));
    chk("rst_rr_ptr", 256'(dut.r_rr_ptr), 256'(0));
    chk("rst_sel", 256'(dut.r_sel), 256'(0));
    chk("rst_req_q", 256'(dut.r_req), 256'(0));
    chk("rst_bypass_req", 256'(bif.bypass_req_o), 256'(0));
    chk_quiet("rst_rsp", -1);
    rst_i = 1'b0;

    // single read from port 1
    step();
    bif.req_i[1] = rd1; #1;
    chk("rd_not_yet_issued", 256'(bif.bypass_req_o.req), 256'(0));
    step(); #1;
    chk("rd_issue", 256'(bif.bypass_req_o), 256'(exp_issue(rd1, 1)));
    chk("rd_id", 256'(bif.bypass_req_o.id), 256'(1));
    chk("rd_no_gnt_yet", 256'(bif.rsp_o[1].gnt), 256'(0));
    step();
    bif.bypass_rsp_i.gnt = 1'b1; #1;
    chk("rd_gnt", 256'(bif.rsp_o[1].gnt), 256'(1));
    chk("rd_gnt_no_valid", 256'(bif.rsp_o[1].valid), 256'(0));
    chk_quiet("rd_gnt_others", 1);
    step();
    bif.bypass_rsp_i.gnt = 1'b0;
    bif.req_i[1].req = 1'b0; #1;
    chk("rd_req_drop", 256'(bif.bypass_req_o.req), 256'(0));
    chk("rd_wait_state", 256'(dut.r_state), 256'(WAIT_RSP));
    chk("rd_rr_ptr", 256'(dut.r_rr_ptr), 256'(2));
    step(); #1;
    chk("rd_no_valid_yet", 256'(bif.rsp_o[1].valid), 256'(0));
    step();
    bif.bypass_rsp_i.valid = 1'b1;
    bif.bypass_rsp_i.rdata = 64'hDEAD_BEEF_0123_4567; #1;
    chk("rd_valid", 256'(bif.rsp_o[1].valid), 256'(1));
    chk("rd_rdata", 256'(bif.rsp_o[1].rdata), 256'(64'hDEAD_BEEF_0123_4567));
    chk_quiet("rd_valid_others", 1);
    step();
    bif.bypass_rsp_i = '0; #1;
    chk("rd_back_idle", 256'(dut.r_state), 256'(IDLE));
    chk("rd_rsp_clear", 256'(bif.rsp_o[1]), 256'(0));

    // spurious gnt/valid while idle
    bif.bypass_rsp_i.gnt   = 1'b1;
    bif.bypass_rsp_i.valid = 1'b1;
    bif.bypass_rsp_i.rdata = 64'hFFFF_FFFF_FFFF_FFFF; #1;
    chk_quiet("noise_rsp", -1);
    chk("noise_bypass_req", 256'(bif.bypass_req_o), 256'(0));
    step(); #1;
    chk("noise_state", 256'(dut.r_state), 256'(IDLE));
    chk("noise_rr_ptr", 256'(dut.r_rr_ptr), 256'(2));
    bif.bypass_rsp_i = '0;

    // fast response: gnt and valid together, AMO fields pass through
    bif.req_i[0] = fr0;
    step(); #1;
    chk("fast_issue", 256'(bif.bypass_req_o), 256'(exp_issue(fr0, 0)));
    chk("fast_amo", 256'(bif.bypass_req_o.amo), 256'(4'h5));
    bif.bypass_rsp_i.gnt   = 1'b1;
    bif.bypass_rsp_i.valid = 1'b1;
    bif.bypass_rsp_i.rdata = 64'h0BAD_F00D_CAFE_0001; #1;
    chk("fast_gnt", 256'(bif.rsp_o[0].gnt), 256'(1));
    chk("fast_valid", 256'(bif.rsp_o[0].valid), 256'(1));
    chk("fast_rdata", 256'(bif.rsp_o[0].rdata), 256'(64'h0BAD_F00D_CAFE_0001));
    step();
    bif.bypass_rsp_i = '0; #1;
    chk("fast_idle", 256'(dut.r_state), 256'(IDLE));
    chk("fast_gap_no_req", 256'(bif.bypass_req_o.req), 256'(0));
    chk("fast_rr_ptr", 256'(dut.r_rr_ptr), 256'(1));
    step(); #1;
    chk("fast_reissue", 256'(bif.bypass_req_o.req), 256'(1));
    chk("fast_reissue_id", 256'(bif.bypass_req_o.id), 256'(0));
    bif.bypass_rsp_i.gnt   = 1'b1;
    bif.bypass_rsp_i.valid = 1'b1;
    step();
    bif.bypass_rsp_i = '0;
    bif.req_i[0] = '0; #1;
    chk("fast_done_idle", 256'(dut.r_state), 256'(IDLE));

    // contention from reset: ports 0, 2, 3 keep requesting
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    bif.req_i[0] = cont[0];
    bif.req_i[2] = cont[2];
    bif.req_i[3] = cont[3]; #1;
    for (int t = 0; t < 6; t++) begin
      int waited;
      waited = 0;
      while (!bif.bypass_req_o.req && waited < 8) begin
        step(); #1;
        waited++;
      end
      chk("cont_wait_bound", 256'(waited < 8), 256'(1));
      chk("cont_id", 256'(bif.bypass_req_o.id), 256'(order[t]));
      chk("cont_addr", 256'(bif.bypass_req_o.addr), 256'(cont[order[t]].addr));
      bif.bypass_rsp_i.gnt   = 1'b1;
      bif.bypass_rsp_i.valid = 1'b1;
      bif.bypass_rsp_i.rdata = 64'(t); #1;
      chk("cont_gnt", 256'(bif.rsp_o[order[t]].gnt), 256'(1));
      chk("cont_rdata", 256'(bif.rsp_o[order[t]].rdata), 256'(t));
      step();
      bif.bypass_rsp_i = '0; #1;
      chk("cont_rr_ptr", 256'(dut.r_rr_ptr), 256'(ptr_exp[t]));
    end
    for (int i = 0; i < 4; i++) bif.req_i[i] = '0;

    // backpressured write from port 3
    step();
    bif.req_i[3] = wr3;
    step(); #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_stable", 256'(bif.bypass_req_o), 256'(exp_issue(wr3, 3)));
      chk("bp_no_gnt", 256'(bif.rsp_o[3].gnt), 256'(0));
      step(); #1;
    end
    chk("bp_we", 256'(bif.bypass_req_o.we), 256'(1));
    chk("bp_be", 256'(bif.bypass_req_o.be), 256'(8'h0F));
    bif.bypass_rsp_i.gnt = 1'b1; #1;
    chk("bp_gnt", 256'(bif.rsp_o[3].gnt), 256'(1));
    chk("bp_stable_at_gnt", 256'(bif.bypass_req_o), 256'(exp_issue(wr3, 3)));
    step();
    bif.bypass_rsp_i.gnt = 1'b0;
    bif.req_i[3].req = 1'b0; #1;
    chk("bp_req_drop", 256'(bif.bypass_req_o.req), 256'(0));
    chk("bp_wait_state", 256'(dut.r_state), 256'(WAIT_RSP));
    step();
    bif.bypass_rsp_i.valid = 1'b1; #1;
    chk("bp_ack", 256'(bif.rsp_o[3].valid), 256'(1));
    step();
    bif.bypass_rsp_i = '0; #1;
    chk("bp_idle", 256'(dut.r_state), 256'(IDLE));
    chk("bp_rr_ptr", 256'(dut.r_rr_ptr), 256'(0));

    // reset while waiting for the response
    bif.req_i[2] = rq2;
    step();
    bif.bypass_rsp_i.gnt = 1'b1;
    step();
    bif.bypass_rsp_i.gnt = 1'b0;
    bif.req_i[2].req = 1'b0; #1;
    chk("mid_wait_state", 256'(dut.r_state), 256'(WAIT_RSP));
    chk("mid_rr_ptr", 256'(dut.r_rr_ptr), 256'(3));
    bif.bypass_rsp_i.valid = 1'b1;
    bif.bypass_rsp_i.rdata = 64'h1234_5678_9ABC_DEF0; #1;
    chk("mid_valid_before_rst", 256'(bif.rsp_o[2].valid), 256'(1));
    rst_i = 1'b1; #1;
    chk("mid_rst_rsp", 256'(bif.rsp_o[2]), 256'(0));
    chk("mid_rst_bypass_req", 256'(bif.bypass_req_o), 256'(0));
    chk("mid_rst_state", 256'(dut.r_state), 256'(IDLE));
    chk("mid_rst_rr_ptr", 256'(dut.r_rr_ptr), 256'(0));
    chk("mid_rst_req_q", 256'(dut.r_req), 256'(0));
    step();
    bif.bypass_rsp_i = '0;
    rst_i = 1'b0;
    bif.req_i[0] = ra0;
    bif.req_i[1] = rb1;
    step(); #1;
    chk("post_rst_winner", 256'(bif.bypass_req_o.id), 256'(0));
    chk("post_rst_issue", 256'(bif.bypass_req_o), 256'(exp_issue(ra0, 0)));
    bif.bypass_rsp_i.gnt   = 1'b1;
    bif.bypass_rsp_i.valid = 1'b1;
    step();
    bif.bypass_rsp_i = '0;
    for (int i = 0; i < 4; i++) bif.req_i[i] = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/std_bypass_arbiter.md
# std_bypass_arbiter

Arbitrates uncached (bypass) requests from `NR_PORTS` data-cache clients onto the single bypass channel of the standard cache subsystem's miss/AXI adapter, one transaction in flight at a time. Sits directly upstream of the bypass port of the miss handler. It consumes `bypass_req_t` from each client, issues one to the adapter, and routes the returning `bypass_rsp_t` (grant, valid, rdata) back to the winning client. Arbitration is round-robin, so no client starves.

## Interface
- `NR_PORTS`, default 4: number of client ports, 2..8.
- `clk_i` input, 1: clock.
- `rst_i` input, 1: reset; one clock; asynchronous, active-high.
- `req_i` input, `NR_PORTS` x `bypass_req_t`: client requests; `.req` is held with stable payload until the matching `rsp_o.gnt`.
- `rsp_o` output, `NR_PORTS` x `bypass_rsp_t`: per-client grant, valid and rdata.
- `bypass_req_o` output, `bypass_req_t`: request to the miss handler.
- `bypass_rsp_i` input, `bypass_rsp_t`: grant, valid and rdata from the miss handler.

## Operation
- FSM states are `IDLE`, `ISSUE` and `WAIT_RSP`.
- `IDLE`:
  - If any `req_i[i].req` is set, the winner is the first requesting port at or after `rr_ptr`, scanning with wrap modulo `NR_PORTS`.
  - The winner's full payload is latched into `req_q`, its index into `sel_q`, and the FSM moves to `ISSUE`.
  - No requests: the FSM stays in `IDLE`.
- `ISSUE`:
  - `bypass_req_o` = `req_q` with `.req`=1 and `.id` = `sel_q` (zero-extended to 4 bits). All other fields pass through unchanged.
  - On `bypass_rsp_i.gnt`: `rsp_o[sel_q].gnt`=1 in the same cycle and `rr_ptr` ← (`sel_q`+1) mod `NR_PORTS`.
  - If `bypass_rsp_i.valid` is also set in that cycle, the FSM goes to `IDLE`; otherwise it goes to `WAIT_RSP`.
- `WAIT_RSP`:
  - On `bypass_rsp_i.valid`: `rsp_o[sel_q].valid`=1 and `rsp_o[sel_q].rdata`=`bypass_rsp_i.rdata` in the same cycle, then the FSM goes to `IDLE`.
- Reads and writes are treated identically. The miss handler returns exactly one `valid` per granted request (write ack for stores), and rdata is don't-care for writes.
- AMO requests (`reqtype`/`amo` fields) pass through untouched.
- `bypass_rsp_i.gnt`/`valid` outside `ISSUE`/`WAIT_RSP` are ignored. A `valid` during `ISSUE` without `gnt` is a protocol violation and is flagged by an assertion.
- Non-selected ports always see gnt=0, valid=0, rdata=0.

## Timing
- Reset values:
  - State `IDLE`, `rr_ptr`=0, `sel_q`=0, `req_q`='0.
  - `bypass_req_o`='0 and all `rsp_o`='0.
- Latency:
  - Client `req` to `bypass_req_o.req` is 1 cycle: arbitration in `IDLE`, registered issue.
  - Downstream `gnt` to client `gnt` is 0 cycles (combinational).
  - Downstream `valid` to client `valid` is 0 cycles (combinational).
- Minimum back-to-back spacing is one `IDLE` cycle between transactions. With gnt+valid in the same cycle, throughput is 1 transaction per 2 cycles.
- `bypass_req_o` is stable for all `ISSUE` cycles while gnt is low and never changes before gnt. `.req` drops in the cycle after gnt.
- A client that dropped `req` before its grant is still served from `req_q` (protocol forbids this; an assertion flags it).
- The winning client's request, still high in the `IDLE` cycle after completion, is a new request and is arbitrated normally. Round-robin places it last.
- `rst_i` mid-transaction (`ISSUE` or `WAIT_RSP`):
  - Everything returns to reset values asynchronously and the in-flight transaction is abandoned.
  - The miss handler shares the same reset.

## Structure
- `std_cache_pkg` additions:
  - `bypass_arb_state_e` (2-bit enum `IDLE`/`ISSUE`/`WAIT_RSP`).
  - Existing `bypass_req_t`/`bypass_rsp_t` reused unchanged.
- One sub-module, `bypass_rr_picker`: combinational first-set-from-pointer search (`NR_PORTS` request bits plus pointer in; one-hot and index out, plus `any`). Its one-hot output follows the same convention as `get_victim_cl`.
- Registers (FSM, `rr_ptr`, `sel_q`, `req_q`) live in `std_bypass_arbiter`.

## Test plan
- Single read:
  - Stimulus: port 1 reads addr 0x8000_0010, size 3; gnt 2 cycles later, valid 3 cycles after that, rdata 0xDEAD_BEEF_0123_4567.
  - Response: `bypass_req_o.req` asserted 1 cycle after `req_i[1]` with id=1. `rsp_o[1].gnt` pulses on gnt. `rsp_o[1].valid` carries the rdata. Other ports stay 0.
- Contention:
  - Stimulus: ports 0, 2 and 3 request simultaneously from reset, each re-requesting immediately after completion.
  - Response: service order 0, 2, 3, 0, 2, 3; `rr_ptr` checked after each grant.
- Fast response:
  - Stimulus: gnt and valid in the same cycle.
  - Response: client gnt and valid in the same cycle, FSM back to `IDLE` next cycle, next transaction issued 2 cycles after the previous issue.
- Backpressure write:
  - Stimulus: port 3 write, be=0x0F, wdata 0x1111_2222_3333_4444; gnt held low 5 cycles.
  - Response: `bypass_req_o` bit-identical for all 5 cycles, we=1, be=0x0F. `.req` drops the cycle after gnt; the write ack produces `rsp_o[3].valid`.
- Reset mid-operation:
  - Stimulus: assert `rst_i` in `WAIT_RSP`.
  - Response: all outputs 0 immediately (asynchronous), `rr_ptr`=0. After release, port 0 wins over a simultaneous port 1 request.
- Idle noise:
  - Stimulus: spurious `bypass_rsp_i.valid` and `gnt` in `IDLE`.
  - Response: no `rsp_o` activity and no state change.
